// File: rtl/mem_spi_responder.sv
`timescale 1ns/1ps
// Memory-side SPI mode-0 responder: turns control-FSM read/write requests into flash/RAM SPI transactions.
// Optional macro MEM_SPI_SEQ_READ_EN keeps flash selected to allow short sequential-read continuations.
module mem_spi_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int CLK_DIV        = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                mem_ctrl_op,
    input  logic                      addr_sel,
    input  logic [ADDR_WIDTH-1:0]     addr_pc,
    input  logic [ADDR_WIDTH-1:0]     addr_mar,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_flash_n,
    output logic                      spi_cs_ram_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int TX_W  = 32 + DATA_BUS_WIDTH;
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT  = 6'(TX_W - 1);
    localparam logic [5:0] DATA_BIT0 = 6'd32;

`ifdef MEM_SPI_SEQ_READ_EN
    localparam logic SEQ_EN = 1'b1;
`else
    localparam logic SEQ_EN = 1'b0;
`endif

    logic [2:0]                state_r, state_s;
    logic                      go_r, go_s;
    logic                      gap_r, gap_s;
    logic [DIV_W-1:0]          div_r, div_s;
    logic [5:0]                bit_r, bit_s;
    logic [TX_W-1:0]           tx_r, tx_s;
    logic [DATA_BUS_WIDTH-1:0] rx_r, rx_s;
    logic                      write_r, write_s;
    logic                      sel_r, sel_s;
    logic [23:0]               addr_r, addr_s;
    logic [DATA_BUS_WIDTH-1:0] wdata_r, wdata_s;
    logic                      sclk_r, sclk_s;
    logic                      mosi_r, mosi_s;
    logic                      cs_flash_r, cs_flash_s;
    logic                      cs_ram_r, cs_ram_s;
    logic                      done_r, done_s;
    logic [DATA_BUS_WIDTH-1:0] dout_r, dout_s;
    logic                      seq_valid_r, seq_valid_s;
    logic [23:0]               seq_addr_r, seq_addr_s;
    logic                      start_s;
    logic                      seq_hit_s;

    // Next-state and next-output computation for the whole transaction engine.
    always_comb begin
        state_s     = state_r;
        go_s        = go_r;
        gap_s       = gap_r;
        div_s       = div_r;
        bit_s       = bit_r;
        tx_s        = tx_r;
        rx_s        = rx_r;
        write_s     = write_r;
        sel_s       = sel_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        sclk_s      = sclk_r;
        mosi_s      = mosi_r;
        cs_flash_s  = cs_flash_r;
        cs_ram_s    = cs_ram_r;
        done_s      = 1'b0;
        dout_s      = dout_r;
        seq_valid_s = seq_valid_r;
        seq_addr_s  = seq_addr_r;
        start_s     = 1'b0;
        seq_hit_s   = SEQ_EN && seq_valid_r && !write_r && !sel_r && (addr_r == seq_addr_r);

        case (state_r)
            S_IDLE: begin
                if (go_r) begin
                    if (gap_r) begin
                        if (div_r == GAP_LAST) begin
                            gap_s   = 1'b0;
                            div_s   = '0;
                            start_s = 1'b1;
                        end else begin
                            div_s = div_r + 1'b1;
                        end
                    end else if (SEQ_EN && seq_valid_r && !seq_hit_s) begin
                        // Held flash select must be released before a different access.
                        cs_flash_s  = 1'b1;
                        seq_valid_s = 1'b0;
                        gap_s       = 1'b1;
                        div_s       = '0;
                    end else begin
                        start_s = 1'b1;
                    end
                end else if ((mem_ctrl_op == 2'd1) || (mem_ctrl_op == 2'd2)) begin
                    write_s = (mem_ctrl_op == 2'd2);
                    sel_s   = addr_sel;
                    addr_s  = addr_sel ? 24'(addr_mar) : 24'(addr_pc);
                    wdata_s = data_in;
                    go_s    = 1'b1;
                end else begin
                    go_s = 1'b0;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (div_r == HALF_LAST) begin
                    div_s = '0;
                    if (!sclk_r) begin
                        sclk_s = 1'b1;
                        rx_s   = {rx_r[DATA_BUS_WIDTH-2:0], spi_miso};
                    end else begin
                        sclk_s = 1'b0;
                        if (bit_r == LAST_BIT) begin
                            state_s  = S_DONE;
                            done_s   = 1'b1;
                            mosi_s   = 1'b0;
                            cs_ram_s = 1'b1;
                            if (!write_r) begin
                                dout_s = rx_r;
                            end else begin
                                dout_s = dout_r;
                            end
                            if (SEQ_EN && !write_r && !sel_r) begin
                                seq_valid_s = 1'b1;
                                seq_addr_s  = addr_r + 24'd1;
                            end else begin
                                cs_flash_s = 1'b1;
                            end
                        end else begin
                            bit_s  = bit_r + 6'd1;
                            tx_s   = {tx_r[TX_W-2:0], 1'b0};
                            mosi_s = tx_r[TX_W-2];
                            if (bit_r < 6'd7) begin
                                state_s = S_CMD;
                            end else if (bit_r < 6'd31) begin
                                state_s = S_ADDR;
                            end else begin
                                state_s = S_DATA;
                            end
                        end
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            S_DONE: begin
                // The initiator's request is still stale here, so it is not sampled.
                state_s = S_IDLE;
            end
            default: begin
                state_s    = S_IDLE;
                go_s       = 1'b0;
                gap_s      = 1'b0;
                sclk_s     = 1'b0;
                cs_flash_s = 1'b1;
                cs_ram_s   = 1'b1;
            end
        endcase

        if (start_s) begin
            go_s        = 1'b0;
            seq_valid_s = 1'b0;
            div_s       = '0;
            sclk_s      = 1'b0;
            if (write_r && !sel_r) begin
                state_s = S_DONE;
                done_s  = 1'b1;
            end else if (seq_hit_s) begin
                state_s = S_DATA;
                bit_s   = DATA_BIT0;
                tx_s    = '0;
                mosi_s  = 1'b0;
            end else begin
                state_s = S_CMD;
                bit_s   = 6'd0;
                tx_s    = {(write_r ? CMD_WRITE : CMD_READ), addr_r,
                           (write_r ? wdata_r : {DATA_BUS_WIDTH{1'b0}})};
                mosi_s  = tx_s[TX_W-1];
                if (sel_r) begin
                    cs_ram_s = 1'b0;
                end else begin
                    cs_flash_s = 1'b0;
                end
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            go_r        <= 1'b0;
            gap_r       <= 1'b0;
            div_r       <= '0;
            bit_r       <= 6'd0;
            tx_r        <= '0;
            rx_r        <= '0;
            write_r     <= 1'b0;
            sel_r       <= 1'b0;
            addr_r      <= 24'd0;
            wdata_r     <= '0;
            sclk_r      <= 1'b0;
            mosi_r      <= 1'b0;
            cs_flash_r  <= 1'b1;
            cs_ram_r    <= 1'b1;
            done_r      <= 1'b0;
            dout_r      <= '0;
            seq_valid_r <= 1'b0;
            seq_addr_r  <= 24'd0;
        end else begin
            state_r     <= state_s;
            go_r        <= go_s;
            gap_r       <= gap_s;
            div_r       <= div_s;
            bit_r       <= bit_s;
            tx_r        <= tx_s;
            rx_r        <= rx_s;
            write_r     <= write_s;
            sel_r       <= sel_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            sclk_r      <= sclk_s;
            mosi_r      <= mosi_s;
            cs_flash_r  <= cs_flash_s;
            cs_ram_r    <= cs_ram_s;
            done_r      <= done_s;
            dout_r      <= dout_s;
            seq_valid_r <= seq_valid_s;
            seq_addr_r  <= seq_addr_s;
        end
    end

    assign data_out       = dout_r;
    assign mem_op_done    = done_r;
    assign spi_sclk       = sclk_r;
    assign spi_mosi       = mosi_r;
    assign spi_cs_flash_n = cs_flash_r;
    assign spi_cs_ram_n   = cs_ram_r;

endmodule

// File: tb/tb_mem_spi_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_spi_responder: an SPI slave model feeds MISO and records MOSI,
// expected results are queued per request and compared when mem_op_done arrives.
module tb_mem_spi_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_ctrl_op = 2'd0;
    logic        addr_sel = 1'b0;
    logic [15:0] addr_pc = 16'd0;
    logic [15:0] addr_mar = 16'd0;
    logic [7:0]  data_in = 8'd0;
    logic [7:0]  data_out;
    logic        mem_op_done;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_flash_n;
    logic        spi_cs_ram_n;

    mem_spi_responder #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8), .CLK_DIV(1)) dut (
        .clock(clock), .reset(reset), .mem_ctrl_op(mem_ctrl_op), .addr_sel(addr_sel),
        .addr_pc(addr_pc), .addr_mar(addr_mar), .data_in(data_in), .data_out(data_out),
        .mem_op_done(mem_op_done), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_cs_flash_n(spi_cs_flash_n), .spi_cs_ram_n(spi_cs_ram_n)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int both_low = 0;

    // SPI slave model: count rising SCLK edges, capture MOSI, present MISO MSB first.
    logic [31:0] rises = 32'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] rel;
    logic [63:0] mosi_cap = 64'd0;
    logic [7:0]  miso_byte = 8'd0;
    assign rel = rises - base;
    assign spi_miso = miso_byte[~rel[2:0]];

    always @(posedge spi_sclk) begin
        rises    <= rises + 32'd1;
        mosi_cap <= {mosi_cap[62:0], spi_mosi};
    end

    always @(negedge clock) begin
        if (!spi_cs_flash_n && !spi_cs_ram_n) both_low <= both_low + 1;
    end

    typedef struct {
        logic [7:0]  dout;
        int          lat;
        int          nbits;
        logic [39:0] frame;
        int          cs_cnt;
    } exp_t;
    exp_t sbq[$];

    // reference model state
    logic        m_sv = 1'b0;
    logic [23:0] m_sa = 24'd0;
    logic [7:0]  m_dout = 8'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] op, input logic sel, input logic [15:0] addr,
                           input logic [7:0] din, input logic [7:0] mbyte, input int hold);
        exp_t e;
        logic hit, gap, wf, done_seen;
        logic [23:0] a24;
        int cyc, cs_cnt, extra;
        a24 = {8'h00, addr};
        wf  = (op == 2'd2) && !sel;
        hit = m_sv && (op == 2'd1) && !sel && (a24 == m_sa);
        gap = m_sv && !hit;
        e.lat    = (wf ? 1 : (hit ? 17 : 81)) + (gap ? 2 : 0);
        e.nbits  = wf ? 0 : (hit ? 8 : 40);
        e.frame  = {((op == 2'd2) ? 8'h02 : 8'h03), a24, ((op == 2'd2) ? din : 8'h00)};
        e.cs_cnt = wf ? (m_sv ? 1 : 0) : (hit ? 17 : (80 + ((m_sv && !sel) ? 1 : 0)));
        if (op == 2'd1) m_dout = mbyte;
        e.dout = m_dout;
`ifdef MEM_SPI_SEQ_READ_EN
        m_sv = (op == 2'd1) && !sel;
        m_sa = a24 + 24'd1;
`endif
        sbq.push_back(e);

        miso_byte   = mbyte;
        base        = rises;
        mem_ctrl_op = op;
        addr_sel    = sel;
        addr_pc     = sel ? 16'hFFFF : addr;
        addr_mar    = sel ? addr : 16'hFFFF;
        data_in     = din;
        cyc = 0; cs_cnt = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (mem_op_done) done_seen = 1'b1;
            else if ((sel ? spi_cs_ram_n : spi_cs_flash_n) == 1'b0) cs_cnt++;
            if (cyc == 5) begin
                addr_pc  = ~addr_pc;
                addr_mar = ~addr_mar;
                data_in  = ~data_in;
                addr_sel = ~addr_sel;
            end
        end
        e = sbq.pop_front();
        check("done_seen", done_seen, 1'b1);
        check("latency", cyc - 1, e.lat);
        check("data_out", data_out, e.dout);
        check("sclk_bits", rel, e.nbits);
        check("cs_low_cycles", cs_cnt, e.cs_cnt);
        if (e.nbits == 40) begin
            if (op == 2'd2) check("mosi_frame", mosi_cap[39:0], e.frame);
            else check("mosi_frame", {mosi_cap[39:8], 8'h00}, e.frame);
        end
        if (hold == 0) mem_ctrl_op = 2'd0;
        @(negedge clock);
        check("done_pulse_width", mem_op_done, 1'b0);
        mem_ctrl_op = 2'd0;
        extra = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_op_done) extra++;
        end
        check("no_extra_done", extra, 0);
        check("no_extra_sclk", rel, e.nbits);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_cs_flash", spi_cs_flash_n, 1'b1);
        check("rst_cs_ram", spi_cs_ram_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_done", mem_op_done, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // flash read, request held one cycle past done
        request(2'd1, 1'b0, 16'h0012, 8'h00, 8'hA5, 1);
        // RAM write, data_out must keep 0xA5
        request(2'd2, 1'b1, 16'h0034, 8'h5A, 8'hFF, 0);
        // flash write: no SPI activity
        request(2'd2, 1'b0, 16'h0077, 8'h99, 8'hFF, 0);
        request(2'd1, 1'b1, 16'hBEEF, 8'h00, 8'hC3, 0);
        request(2'd1, 1'b0, 16'h1234, 8'h00, 8'h3C, 0);

        // reset during the address phase of a RAM read
        miso_byte   = 8'h00;
        base        = rises;
        mem_ctrl_op = 2'd1;
        addr_sel    = 1'b1;
        addr_mar    = 16'h0BCD;
        repeat (30) @(negedge clock);
        check("abort_in_progress", spi_cs_ram_n, 1'b0);
        reset = 1'b0;
        mem_ctrl_op = 2'd0;
        @(negedge clock);
        check("abort_cs_flash", spi_cs_flash_n, 1'b1);
        check("abort_cs_ram", spi_cs_ram_n, 1'b1);
        check("abort_sclk", spi_sclk, 1'b0);
        check("abort_done", mem_op_done, 1'b0);
        check("abort_data_out", data_out, 8'h00);
        reset  = 1'b1;
        m_sv   = 1'b0;
        m_dout = 8'h00;
        repeat (2) @(negedge clock);
        request(2'd1, 1'b0, 16'h0000, 8'h00, 8'h81, 0);

`ifdef MEM_SPI_SEQ_READ_EN
        request(2'd1, 1'b0, 16'h0040, 8'h00, 8'h11, 0);
        request(2'd1, 1'b0, 16'h0041, 8'h00, 8'h22, 0);
        request(2'd1, 1'b0, 16'h0050, 8'h00, 8'h44, 0);
`endif

        check("one_cs_low", both_low, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
